dino_input_cond: RTL
====================

// Module: dino_input_cond
// PURPOSE
//   Front-end input conditioner for the dino game. Synchronises and debounces the raw
//   start and jump push-buttons, and merges the keyboard start key into one start event.
//   Sits directly upstream of the game logic: drives its start_pulse (one-cycle) and
//   jump_signal (debounced level) inputs. All logic is in the pclk domain.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000  pclk cycles an input must stay stable to be accepted (min 2)
//   CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES-1
//   START_KEY        9'h05A  keyboard code (Enter) that also generates start_pulse
// PORTS
//   pclk            in   1  pixel/system clock
//   rst             in   1  asynchronous, active-high reset
//   btn_start_raw   in   1  raw start button, asynchronous, bouncy
//   btn_jump_raw    in   1  raw jump button, asynchronous, bouncy
//   key_valid       in   1  keyboard decoder event strobe/level (pclk domain)
//   last_change     in   9  keyboard code of latest make/break event
//   key_start_down  in   1  key_down[START_KEY] from the keyboard decoder (1 = held)
//   start_pulse     out  1  one-cycle start request (button press or START_KEY make)
//   jump_signal     out  1  debounced jump button level
//   btn_start_db    out  1  debounced start button level (debug/LED)
// BEHAVIOUR
//   Reset: async on rst; all sync flops, FSMs (S_LOW), counters (0), prev_key_valid (0),
//     and all outputs (0) clear immediately. Reset mid-debounce discards progress.
//   Synchroniser: 2 flops per button; FSMs see only the 2nd flop (sync_*).
//   Debounce FSM, one instance per button, 2-bit state, CNT_W counter:
//     S_LOW:      sync=1 -> S_RISE_CHK, cnt<=0.
//     S_RISE_CHK: sync=0 -> S_LOW, cnt<=0; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH;
//                 else cnt<=cnt+1.
//     S_HIGH:     sync=0 -> S_FALL_CHK, cnt<=0.
//     S_FALL_CHK: sync=1 -> S_HIGH, cnt<=0; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW;
//                 else cnt<=cnt+1.
//     Debounced level = 1 in S_HIGH and S_FALL_CHK; registered, so it changes on the same
//     edge as the state. The counter never wraps: it is bounded by the terminal compare.
//   Latency: raw goes high before edge 1 and stays high -> S_HIGH and level=1 after edge
//     DEBOUNCE_CYCLES+3. Release is symmetric. Any pulse or gap shorter than
//     DEBOUNCE_CYCLES cycles (as seen at sync) is rejected.
//   Start sources (both registered into start_pulse):
//     btn: start FSM transition S_RISE_CHK->S_HIGH, raised on that same edge.
//     key: key_valid & ~prev_key_valid & (last_change==START_KEY) & key_start_down.
//       Break events are ignored because key_start_down=0. If key_valid=1 on the first
//       cycle after reset, that counts as a rising edge.
//   start_pulse = OR of both sources, high for exactly 1 cycle. Coincident sources
//     give a single pulse. Sources on back-to-back cycles give back-to-back pulses.
//   A button held through reset release is re-debounced and produces exactly one start_pulse.
//   Holding the start button produces no further pulses. A new pulse requires a full
//     debounced release and press.
//   jump_signal = debounced jump level. Jump has no pulse output; the game samples the level.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CNT_W=3)
//   Start held high from cycle 0 -> start_pulse=1 only after edge 7, btn_start_db=1 from edge 7 on.
//   Jump toggled 1,0,1,0 every cycle for 12 cycles, then 0 -> jump_signal stays 0 throughout.
//   Jump high 10 cycles, then bounce low 2 cycles, then high 10 -> jump_signal rises once, no dip.
//   key_valid rises with last_change=9'h05A, key_start_down=1 -> start_pulse is 1 for one cycle;
//     same with key_start_down=0, or code 9'h029 -> no pulse.
//   Button accept edge coincides with key event -> exactly one start_pulse cycle.
//   rst pulsed while start is in S_RISE_CHK with cnt=2, button kept high -> no pulse before reset
//     release; one pulse 7 edges after release.

Source files
------------

// File: rtl/dino_input_cond.sv
// -----------------------------------------------------------------------------
// dino_input_cond
//   Input conditioner that sits in front of the dino game logic. It
//   synchronises and debounces the raw start and jump push-buttons. It also
//   merges the keyboard start key (make event of START_KEY) with the debounced
//   start-button press into a single one-cycle start request.
//   Everything runs in the pclk domain.
//
// Ports
//   pclk            in   pixel/system clock
//   rst             in   asynchronous, active-high reset
//   btn_start_raw   in   raw start button (asynchronous, bouncy)
//   btn_jump_raw    in   raw jump button (asynchronous, bouncy)
//   key_valid       in   keyboard decoder event strobe/level
//   last_change     in   keyboard code of the latest make/break event
//   key_start_down  in   1 while START_KEY is held
//   start_pulse     out  one-cycle start request (button press or key make)
//   jump_signal     out  debounced jump button level
//   btn_start_db    out  debounced start button level (debug/LED)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// dino_debounce
//   2-flop synchroniser followed by a 4-state debounce FSM. An input level is
//   accepted only after it has been stable at the synchroniser output for
//   DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   pclk    in   clock
//   rst     in   asynchronous, active-high reset
//   raw     in   raw asynchronous input
//   level   out  registered debounced level
//   accept  out  combinational: this edge completes a debounced press
// -----------------------------------------------------------------------------
module dino_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic pclk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic accept
);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            level_nxt;

  // Stage p0/p1: metastability synchroniser; the FSM only ever sees sync_p1
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce FSM: state, counter and level register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  // The terminal compare stops the counter before it can wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      S_LOW: begin
        if (sync_p1) begin
          state_nxt = S_RISE_CHK;
          cnt_nxt   = '0;
        end
      end
      S_RISE_CHK: begin
        if (!sync_p1) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync_p1) begin
          state_nxt = S_FALL_CHK;
          cnt_nxt   = '0;
        end
      end
      S_FALL_CHK: begin
        if (sync_p1) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so it moves on the same edge
    // as the state itself.
    level_nxt = (state_nxt == S_HIGH) || (state_nxt == S_FALL_CHK);
  end

endmodule

module dino_input_cond #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         CNT_W           = 18,
  parameter logic [8:0] START_KEY       = 9'h05A
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       btn_start_raw,
  input  logic       btn_jump_raw,
  input  logic       key_valid,
  input  logic [8:0] last_change,
  input  logic       key_start_down,
  output logic       start_pulse,
  output logic       jump_signal,
  output logic       btn_start_db
);

  logic start_accept;
  logic jump_accept;
  logic prev_key_valid;
  logic key_evt;

  dino_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_start (
    .pclk   (pclk),
    .rst    (rst),
    .raw    (btn_start_raw),
    .level  (btn_start_db),
    .accept (start_accept)
  );

  dino_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_jump (
    .pclk   (pclk),
    .rst    (rst),
    .raw    (btn_jump_raw),
    .level  (jump_signal),
    .accept (jump_accept)
  );

  // Only the make event counts: a break for START_KEY arrives with
  // key_start_down already low. prev_key_valid clears in reset, so a
  // key_valid that is high on the first cycle after reset still fires.
  assign key_evt = key_valid & ~prev_key_valid &
                   (last_change == START_KEY) & key_start_down;

  // Output stage: both start sources merge into one registered pulse
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      prev_key_valid <= 1'b0;
      start_pulse    <= 1'b0;
    end else begin
      prev_key_valid <= key_valid;
      start_pulse    <= start_accept | key_evt;
    end
  end

  // Jump is consumed as a level by the game; its accept strobe has no user.
  logic unused_jump_accept;
  assign unused_jump_accept = jump_accept;

endmodule
